// File: rtl/mvau_pkg.sv
// Shared MVAU definitions used by the PE accumulator family.
//   MAX_ACC_W      : widest accumulator the helper functions can describe.
//   acc_word_t     : container type for accumulator bounds (low ACC_W bits used).
//   acc_max/acc_min: largest/smallest representable value of an ACC_W-bit word.
//   acc_params_ok  : legality of an accumulator parameter set.
//   cnt_width      : fold counter width for a given synapse fold (>= 1 bit).
package mvau_pkg;

  localparam int MAX_ACC_W = 64;

  typedef logic [MAX_ACC_W-1:0] acc_word_t;

  // Largest value as an ACC_W-bit pattern: 0111..1 signed, 111..1 unsigned.
  function automatic acc_word_t acc_max(int acc_w, bit is_signed);
    acc_word_t r;
    int        ones;
    r    = '0;
    ones = is_signed ? acc_w - 1 : acc_w;
    for (int i = 0; i < MAX_ACC_W; i++) begin
      if (i < ones) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Smallest value as an ACC_W-bit pattern: 100..0 signed, 0 unsigned.
  function automatic acc_word_t acc_min(int acc_w, bit is_signed);
    acc_word_t r;
    r = '0;
    if (is_signed) r[acc_w-1] = 1'b1;
    return r;
  endfunction

  function automatic bit acc_params_ok(int in_w, int acc_w, int sf);
    return (in_w >= 1) && (acc_w >= in_w) && (acc_w <= MAX_ACC_W) && (sf >= 1);
  endfunction

  function automatic int cnt_width(int sf);
    return (sf > 1) ? $clog2(sf) : 1;
  endfunction

endpackage

// File: rtl/mvu_acc_addsat.sv
// Combinational extend-add-clamp stage for PE accumulators.
//   base : running ACC_W-bit accumulator value (already clamped/wrapped).
//   in   : IN_W-bit partial sum, sign- or zero-extended per SIGNED.
//   sum  : base + in, clamped (SATURATE=1) or wrapped (SATURATE=0).
//   ovf  : exact sum was not representable in ACC_W bits.
module mvu_acc_addsat
  import mvau_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int ACC_W    = 24,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 0
) (
  input  logic [ACC_W-1:0] base,
  input  logic [IN_W-1:0]  in,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  localparam acc_word_t        MAX_W = acc_max(ACC_W, SIGNED != 0);
  localparam acc_word_t        MIN_W = acc_min(ACC_W, SIGNED != 0);
  localparam logic [ACC_W-1:0] MAX_V = MAX_W[ACC_W-1:0];
  localparam logic [ACC_W-1:0] MIN_V = MIN_W[ACC_W-1:0];

  // One guard bit makes the sum exact for both signed and unsigned operands.
  logic [ACC_W:0] base_x;
  logic [ACC_W:0] in_x;
  logic [ACC_W:0] sum_x;

  if (SIGNED != 0) begin : g_signed
    assign base_x = {base[ACC_W-1], base};
    assign in_x   = {{(ACC_W+1-IN_W){in[IN_W-1]}}, in};
  end else begin : g_unsigned
    assign base_x = {1'b0, base};
    assign in_x   = {{(ACC_W+1-IN_W){1'b0}}, in};
  end

  assign sum_x = base_x + in_x;

  always_comb begin
    // NOTE: every output gets a default first so no path through this block can infer a latch.
    ovf = (SIGNED != 0) ? (sum_x[ACC_W] ^ sum_x[ACC_W-1]) : sum_x[ACC_W];
    sum = sum_x[ACC_W-1:0];
    if ((SATURATE != 0) && ovf) begin
      // Signed: the guard bit is the true sign, so it picks the rail.
      sum = ((SIGNED != 0) && sum_x[ACC_W]) ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/mvu_pe_acc_fold.sv
// Self-folding PE accumulator on the MVAU stream path.
// Accumulates SF beats (or fewer when in_last is set) from the adder tree
// and presents the sum on a valid/ready output held until taken.
//   clk, rst          : clock, synchronous active-high reset.
//   in_v/in_rdy       : input beat handshake; in_acc is the partial sum.
//   in_last           : forces the current beat to close the fold.
//   out_v/out_rdy     : result handshake; out_acc/out_ovf stable while stalled.
//   out_ovf           : an overflow/clamp happened somewhere in this fold.
module mvu_pe_acc_fold
  import mvau_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int ACC_W    = 24,
  parameter int SF       = 4,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_v,
  output logic             in_rdy,
  input  logic [IN_W-1:0]  in_acc,
  input  logic             in_last,
  output logic             out_v,
  input  logic             out_rdy,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  localparam int               CNT_W    = cnt_width(SF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SF - 1);

  if (!acc_params_ok(IN_W, ACC_W, SF)) begin : g_param_check
    $error("mvu_pe_acc_fold: need 1 <= IN_W <= ACC_W <= %0d and SF >= 1", MAX_ACC_W);
  end

  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic             fin;
  logic             acc_en;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] sum_r;
  logic             ov_now;

  assign fin    = (cnt == CNT_LAST) || in_last;
  // Only a closing beat needs the output slot; partial beats always flow.
  assign in_rdy = !fin || !out_v || out_rdy;
  assign acc_en = in_v && in_rdy;
  // The first beat starts from zero, so acc never needs clearing between folds.
  assign base   = (cnt == '0) ? '0 : acc;

  mvu_acc_addsat #(
    .IN_W    (IN_W),
    .ACC_W   (ACC_W),
    .SIGNED  (SIGNED),
    .SATURATE(SATURATE)
  ) u_addsat (
    .base(base),
    .in  (in_acc),
    .sum (sum_r),
    .ovf (ov_now)
  );

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      ovf     <= 1'b0;
      out_v   <= 1'b0;
      out_acc <= '0;
      out_ovf <= 1'b0;
    end else begin
      if (out_v && out_rdy) out_v <= 1'b0;
      if (acc_en) begin
        if (fin) begin
          // Overrides the clear above: back-to-back results without a bubble.
          out_acc <= sum_r;
          out_ovf <= ovf | ov_now;
          out_v   <= 1'b1;
          cnt     <= '0;
          ovf     <= 1'b0;
        end else begin
          acc <= sum_r;
          cnt <= cnt + CNT_W'(1);
          ovf <= ovf | ov_now;
        end
      end
    end
  end

endmodule
